fpu_issuer: RTL and testbench

Request-side front end for the 6-stage pipelined FPU. It accepts tagged operation requests on a valid/ready port and drives the FPU's `A`/`B`/`sel`/`round_mode`/`start` inputs. It tracks every in-flight operation against the FPU's fixed latency, then returns `{Y, error, overflow, tag}` in order on a valid/ready response port. The FPU cannot stall, so credit-based admission guarantees every issued result has response-buffer space.

---
 rtl/fpu_pkg.sv | 33 +++
 rtl/fpu_rsp_fifo.sv | 77 +++++++
 rtl/fpu_issuer.sv | 148 ++++++++++++++
 tb/tb_fpu_issuer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operation and rounding encodings, pipeline latency,
// and the packed response record carried through the response buffer.
package fpu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } fpu_op_e;

    localparam int unsigned RND_W = 2;

    typedef enum logic [RND_W-1:0] {
        RND_NEAREST_EVEN = 2'b00,
        RND_TO_ZERO      = 2'b01,
        RND_UP           = 2'b10,
        RND_DOWN         = 2'b11
    } fpu_rnd_e;

    localparam int unsigned FPU_LATENCY = 6;

    // Widest request tag the response record can carry; narrower tags are zero-extended.
    localparam int unsigned RSP_TAG_MAX_W = 16;

    typedef struct packed {
        logic [31:0]              y;
        logic                     error;
        logic                     overflow;
        logic [RSP_TAG_MAX_W-1:0] tag;
    } fpu_rsp_t;

endpackage

// File: rtl/fpu_rsp_fifo.sv
// In-order synchronous response FIFO; a pop frees its slot for a push on the same edge.
module fpu_rsp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(push && full && !pop));
        end
    end

endmodule

// File: rtl/fpu_issuer.sv
// Request-side front end for the fixed-latency FPU: registers the FPU drive,
// tracks in-flight tags against the pipeline latency and buffers results in order.
module fpu_issuer
    import fpu_pkg::*;
#(
    parameter int unsigned LATENCY   = FPU_LATENCY,
    parameter int unsigned RSP_DEPTH = 16,
    parameter int unsigned TAG_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [1:0]       req_sel,
    input  logic [1:0]       req_rnd,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic [1:0]       fpu_sel,
    output logic [1:0]       fpu_round_mode,
    output logic             fpu_start,
    input  logic [31:0]      fpu_y,
    input  logic             fpu_error,
    input  logic             fpu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_y,
    output logic             rsp_error,
    output logic             rsp_overflow,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    localparam int unsigned TRK_N = LATENCY + 2;
    localparam int unsigned OCC_W = $clog2(RSP_DEPTH + 1);

    logic [OCC_W-1:0] occ_q, occ_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    fpu_op_e          sel_q, sel_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    logic             start_q, start_d;
    logic [TRK_N-1:0] trk_vld_q, trk_vld_d;
    logic [TAG_W-1:0] trk_tag_q [TRK_N];
    logic [TAG_W-1:0] trk_tag_d [TRK_N];

    logic             accept, pop, push;
    fpu_rsp_t         push_data, head;
    logic             fifo_full, fifo_empty;
    logic [OCC_W-1:0] fifo_count;
    logic             unused_head_tag;

    assign req_ready = (occ_q < OCC_W'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;
    assign push      = trk_vld_q[TRK_N-1];
    assign busy      = (occ_q != '0);

    // The last track stage lines up with the FPU's Y update, so fpu_y is captured on the following edge.
    assign push_data = '{y:        fpu_y,
                         error:    fpu_error,
                         overflow: fpu_overflow,
                         tag:      RSP_TAG_MAX_W'(trk_tag_q[TRK_N-1])};

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        sel_d     = sel_q;
        rnd_d     = rnd_q;
        start_d   = accept;
        trk_vld_d = {trk_vld_q[TRK_N-2:0], accept};
        occ_d     = occ_q;
        trk_tag_d[0] = req_tag;
        for (int unsigned i = 1; i < TRK_N; i++) begin
            trk_tag_d[i] = trk_tag_q[i-1];
        end
        if (accept) begin
            a_d   = req_a;
            b_d   = req_b;
            sel_d = fpu_op_e'(req_sel);
            rnd_d = req_rnd;
        end
        case ({accept, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sel_q     <= OP_ADD;
            rnd_q     <= '0;
            start_q   <= 1'b0;
            trk_vld_q <= '0;
            trk_tag_q <= '{default: '0};
        end else begin
            occ_q     <= occ_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sel_q     <= sel_d;
            rnd_q     <= rnd_d;
            start_q   <= start_d;
            trk_vld_q <= trk_vld_d;
            trk_tag_q <= trk_tag_d;
        end
    end

    fpu_rsp_fifo #(
        .WIDTH ($bits(fpu_rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign fpu_a           = a_q;
    assign fpu_b           = b_q;
    assign fpu_sel         = sel_q;
    assign fpu_round_mode  = rnd_q;
    assign fpu_start       = start_q;
    assign rsp_valid       = !fifo_empty;
    assign rsp_y           = head.y;
    assign rsp_error       = head.error;
    assign rsp_overflow    = head.overflow;
    assign rsp_tag         = head.tag[TAG_W-1:0];
    assign unused_head_tag = ^head.tag;

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (occ_q <= OCC_W'(RSP_DEPTH));
            assert (fifo_count <= occ_q);
            assert (!fifo_full || (occ_q == fifo_count));
        end
    end

endmodule

// File: tb/tb_fpu_issuer.sv
// Directed bench for fpu_issuer with a behavioural 6-stage FPU stub and an in-order response scoreboard.
module tb_fpu_issuer;
    import fpu_pkg::*;

    localparam int unsigned LAT   = 6;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned TW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid, req_ready;
    logic [31:0]   req_a, req_b;
    logic [1:0]    req_sel, req_rnd;
    logic [TW-1:0] req_tag;
    logic [31:0]   fpu_a, fpu_b;
    logic [1:0]    fpu_sel, fpu_round_mode;
    logic          fpu_start;
    logic [31:0]   fpu_y;
    logic          fpu_error, fpu_overflow;
    logic          rsp_valid, rsp_ready;
    logic [31:0]   rsp_y;
    logic          rsp_error, rsp_overflow;
    logic [TW-1:0] rsp_tag;
    logic          busy;

    always #5 clk = ~clk;

    fpu_issuer #(
        .LATENCY   (LAT),
        .RSP_DEPTH (DEPTH),
        .TAG_W     (TW)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_sel        (req_sel),
        .req_rnd        (req_rnd),
        .req_tag        (req_tag),
        .fpu_a          (fpu_a),
        .fpu_b          (fpu_b),
        .fpu_sel        (fpu_sel),
        .fpu_round_mode (fpu_round_mode),
        .fpu_start      (fpu_start),
        .fpu_y          (fpu_y),
        .fpu_error      (fpu_error),
        .fpu_overflow   (fpu_overflow),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_y          (rsp_y),
        .rsp_error      (rsp_error),
        .rsp_overflow   (rsp_overflow),
        .rsp_tag        (rsp_tag),
        .busy           (busy)
    );

    // Stub FPU arithmetic: exact for the 1.0 + 2.0 vector, otherwise an arbitrary but fixed mapping.
    function automatic logic [31:0] model_y(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000 && sel == 2'b00) return 32'h4040_0000;
        return (a + b) ^ {sel, 30'h0};
    endfunction

    function automatic logic model_err(input logic [31:0] b, input logic [1:0] sel);
        return (sel == 2'b11) && (b == 32'h0);
    endfunction

    logic [LAT-1:0] st_v;
    logic [31:0]    st_y [LAT];
    logic           st_e [LAT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_v         <= '0;
            st_y         <= '{default: '0};
            st_e         <= '{default: 1'b0};
            fpu_y        <= '0;
            fpu_error    <= 1'b0;
            fpu_overflow <= 1'b0;
        end else begin
            st_v    <= {st_v[LAT-2:0], fpu_start};
            st_y[0] <= model_y(fpu_a, fpu_b, fpu_sel);
            st_e[0] <= model_err(fpu_b, fpu_sel);
            for (int i = 1; i < LAT; i++) begin
                st_y[i] <= st_y[i-1];
                st_e[i] <= st_e[i-1];
            end
            if (st_v[LAT-1]) begin
                fpu_y        <= st_y[LAT-1];
                fpu_error    <= st_e[LAT-1];
                fpu_overflow <= st_e[LAT-1];
            end
        end
    end

    typedef struct packed {
        logic [31:0]   y;
        logic          e;
        logic          o;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t expq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   accepts = 0;
    int   pops = 0;
    int   cyc = 0;
    int   pop_cyc[$];

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Advance one clock: log the handshakes seen just before the edge, then settle 1 time unit after it.
    task automatic step();
        exp_t got, e;
        if (rst_n && req_valid && req_ready) begin
            expq.push_back('{y: model_y(req_a, req_b, req_sel), e: model_err(req_b, req_sel),
                             o: model_err(req_b, req_sel), tag: req_tag});
            accepts++;
        end
        if (rst_n && rsp_valid && rsp_ready) begin
            pops++;
            pop_cyc.push_back(cyc);
            got = '{y: rsp_y, e: rsp_error, o: rsp_overflow, tag: rsp_tag};
            check("rsp_expected", 64'(expq.size() != 0), 64'd1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                check("rsp_payload", 64'(got), 64'(e));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel,
                           input logic [1:0] rnd, input logic [TW-1:0] tag);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_sel   = sel;
        req_rnd   = rnd;
        req_tag   = tag;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, p0, idx, n;
        bit acc;

        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        req_rnd   = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;

        // Reset values, with a request offered during reset that must be discarded
        repeat (2) @(posedge clk);
        #1;
        set_req(32'h1234_5678, 32'h1, 2'b00, 2'b00, 4'd1);
        #1;
        check("rst_fpu_start", fpu_start, 0);
        check("rst_fpu_a", fpu_a, 0);
        check("rst_fpu_sel", fpu_sel, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_y", rsp_y, 0);
        check("rst_rsp_tag", rsp_tag, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n = 1'b1;
        step();
        check("rst_release_busy", busy, 0);
        check("rst_release_start", fpu_start, 0);

        // Single add: accept at edge k, response visible after edge k+8
        set_req(32'h3F80_0000, 32'h4000_0000, 2'b00, 2'b10, 4'd3);
        step();
        req_valid = 1'b0;
        check("add_start", fpu_start, 1);
        check("add_fpu_a", fpu_a, 32'h3F80_0000);
        check("add_fpu_b", fpu_b, 32'h4000_0000);
        check("add_fpu_rnd", fpu_round_mode, 2'b10);
        check("add_busy", busy, 1);
        step();
        check("add_start_drop", fpu_start, 0);
        check("add_fpu_a_hold", fpu_a, 32'h3F80_0000);
        repeat (6) step();
        check("add_rsp_early", rsp_valid, 0);
        step();
        check("add_rsp_valid", rsp_valid, 1);
        check("add_rsp_y", rsp_y, 32'h4040_0000);
        check("add_rsp_tag", rsp_tag, 3);
        rsp_ready = 1'b1;
        step();
        check("add_drained", rsp_valid, 0);
        check("add_idle", busy, 0);

        // Streaming: 16 back-to-back requests
        pop_cyc.delete();
        p0 = pops;
        for (int i = 0; i < 16; i++) begin
            set_req(32'h3000_0000 + 32'(i) * 32'h0001_0203, 32'h0100_0000 * 32'(i + 1),
                    2'(i), 2'(i >> 2), 4'(i));
            check("stream_ready", req_ready, 1);
            step();
            check("stream_start", fpu_start, 1);
        end
        req_valid = 1'b0;
        step();
        check("stream_start_end", fpu_start, 0);
        n = 0;
        while (pops - p0 < 16 && n < 40) begin
            step();
            n++;
        end
        check("stream_pop_count", 64'(pops - p0), 64'd16);
        if (pop_cyc.size() == 16) begin
            check("stream_pop_span", 64'(pop_cyc[15] - pop_cyc[0]), 64'd15);
        end
        check("stream_idle", busy, 0);

        // Backpressure: 20 offered, 16 accepted while responses are held
        rsp_ready = 1'b0;
        a0 = accepts;
        p0 = pops;
        idx = 0;
        for (int c = 0; c < 25; c++) begin
            if (idx < 20) set_req(32'h4100_0000 + 32'(idx), 32'h0000_0100 * 32'(idx + 1), 2'b10, 2'b01, 4'(idx));
            else req_valid = 1'b0;
            acc = req_valid && req_ready;
            step();
            if (acc) idx++;
        end
        check("bp_accepted", 64'(accepts - a0), 64'd16);
        check("bp_req_ready_low", req_ready, 0);
        check("bp_occ_full", 64'(dut.occ_q), 64'd16);
        check("bp_rsp_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        acc = req_valid && req_ready;
        step();
        if (acc) idx++;
        check("bp_ready_after_pop", req_ready, 1);
        check("bp_occ_after_pop", 64'(dut.occ_q), 64'd15);
        acc = req_valid && req_ready;
        step();
        if (acc) idx++;
        check("bp_occ_pop_accept", 64'(dut.occ_q), 64'd15);
        n = 0;
        while (pops - p0 < 20 && n < 100) begin
            if (idx < 20) set_req(32'h4100_0000 + 32'(idx), 32'h0000_0100 * 32'(idx + 1), 2'b10, 2'b01, 4'(idx));
            else req_valid = 1'b0;
            acc = req_valid && req_ready;
            step();
            if (acc) idx++;
            n++;
        end
        req_valid = 1'b0;
        check("bp_all_done", 64'(pops - p0), 64'd20);
        check("bp_idle", busy, 0);

        // Error and overflow flags travel with their own response
        rsp_ready = 1'b0;
        set_req(32'h40A0_0000, 32'h0, 2'b11, 2'b00, 4'd9);
        step();
        set_req(32'h40A0_0000, 32'h3F80_0000, 2'b11, 2'b00, 4'd10);
        step();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        check("err_rsp_valid", rsp_valid, 1);
        check("err_rsp_error", rsp_error, 1);
        check("err_rsp_overflow", rsp_overflow, 1);
        check("err_rsp_tag", rsp_tag, 9);
        rsp_ready = 1'b1;
        step();
        check("err_next_valid", rsp_valid, 1);
        check("err_next_tag", rsp_tag, 10);
        check("err_next_error", rsp_error, 0);
        check("err_next_overflow", rsp_overflow, 0);
        step();
        check("err_idle", busy, 0);

        // Reset with four operations in flight
        for (int i = 0; i < 4; i++) begin
            set_req(32'h5000_0000 + 32'(i), 32'h0000_0010, 2'b01, 2'b11, 4'(4 + i));
            step();
        end
        req_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_start", fpu_start, 0);
        check("mid_rst_fpu_a", fpu_a, 0);
        check("mid_rst_fpu_rnd", fpu_round_mode, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_req_ready", req_ready, 1);
        expq.delete();
        step();
        rst_n = 1'b1;
        p0 = pops;
        repeat (20) step();
        check("mid_rst_no_rsp", 64'(pops - p0), 64'd0);
        check("mid_rst_quiet", rsp_valid, 0);
        set_req(32'h3F80_0000, 32'h4000_0000, 2'b00, 2'b00, 4'd12);
        step();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        check("post_rst_latency", 64'(n), 64'd8);
        check("post_rst_tag", rsp_tag, 12);
        step();
        check("post_rst_done", 64'(pops - p0), 64'd1);
        check("post_rst_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
